// File: rtl/rsa_pkg.sv
// ============================================================================
// Module  : rsa_pkg
// Brief   : Shared types and index-width helper for the RSA datapath blocks.
// Revision: 1.0  initial release
// ============================================================================
`default_nettype none

package rsa_pkg;

  typedef enum logic [2:0] {
    MMM_IDLE  = 3'd0,
    MMM_LOAD  = 3'd1,
    MMM_ITER  = 3'd2,
    MMM_FINAL = 3'd3,
    MMM_DONE  = 3'd4,
    MMM_FLUSH = 3'd5
  } mmm_state_t;

  // Bit-index width for a WIDTH-bit operand; shared with the exponentiation controller.
  function automatic int idx_width(input int width);
    return (width < 2) ? 1 : $clog2(width);
  endfunction

endpackage

`default_nettype wire

// File: rtl/mmm_ctrl.sv
// ============================================================================
// Module  : mmm_ctrl
// Brief   : Sequencer for one bit-serial Montgomery multiplication.
// Revision: 1.0  initial release
// ============================================================================
`default_nettype none

module mmm_ctrl
  import rsa_pkg::*;
#(
  parameter int WIDTH = 4,
  parameter int IW    = idx_width(WIDTH)
) (
  input  logic          clk,
  input  logic          rstb,
  input  logic          ena,
  input  logic          start,
  input  logic          abort,
  input  logic          ge_m,
  output logic          busy,
  output logic          done,
  output logic          dp_ena,
  output logic          dp_load,
  output logic          dp_clear,
  output logic          dp_sub,
  output logic [IW-1:0] bit_idx
);

  localparam logic [IW-1:0] c_last_idx = IW'(WIDTH - 1);

  mmm_state_t    r_state;
  mmm_state_t    w_state_nxt;
  logic [IW-1:0] r_cnt;
  logic [IW-1:0] w_cnt_nxt;

  logic w_done;
  logic w_dp_ena;
  logic w_dp_load;
  logic w_dp_zero;
  logic w_dp_sub;

  // State register: everything holds while ena is low.
  always_ff @(posedge clk) begin
    if (!rstb) begin
      r_state <= MMM_IDLE;
      r_cnt   <= '0;
    end else if (ena) begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  // Counter is zero outside ITER, so it is always clean on entry.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = '0;
    case (r_state)
      MMM_IDLE: begin
        if (start && !abort) w_state_nxt = MMM_LOAD;
      end
      MMM_LOAD: begin
        w_state_nxt = abort ? MMM_FLUSH : MMM_ITER;
      end
      MMM_ITER: begin
        if (abort) begin
          w_state_nxt = MMM_FLUSH;
        end else if (r_cnt == c_last_idx) begin
          w_state_nxt = MMM_FINAL;
        end else begin
          w_cnt_nxt = r_cnt + 1'b1;
        end
      end
      MMM_FINAL: begin
        w_state_nxt = abort ? MMM_FLUSH : MMM_DONE;
      end
      MMM_DONE:  w_state_nxt = MMM_IDLE;
      MMM_FLUSH: w_state_nxt = MMM_IDLE;
      default:   w_state_nxt = MMM_IDLE;
    endcase
  end

  always_comb begin
    w_done    = 1'b0;
    w_dp_ena  = 1'b0;
    w_dp_load = 1'b0;
    w_dp_zero = 1'b0;
    w_dp_sub  = 1'b0;
    bit_idx   = '0;
    case (r_state)
      MMM_LOAD: begin
        w_dp_ena  = 1'b1;
        w_dp_load = 1'b1;
      end
      MMM_ITER: begin
        w_dp_ena = 1'b1;
        bit_idx  = r_cnt;
      end
      MMM_FINAL: begin
        w_dp_ena = 1'b1;
        w_dp_sub = ge_m;
      end
      MMM_DONE: begin
        w_done = 1'b1;
      end
      MMM_FLUSH: begin
        w_dp_ena  = 1'b1;
        w_dp_zero = 1'b1;
      end
      default: begin
        w_done = 1'b0;
      end
    endcase
  end

  assign busy     = (r_state != MMM_IDLE);
  assign done     = w_done    & ena;
  assign dp_ena   = w_dp_ena  & ena;
  assign dp_load  = w_dp_load & ena;
  assign dp_sub   = w_dp_sub  & ena;
  // dp_clear is active-low toward the datapath.
  assign dp_clear = !(w_dp_zero & ena);

endmodule

`default_nettype wire

// File: tb/tb_mmm_ctrl.sv
// ============================================================================
// Module  : tb_mmm_ctrl
// Brief   : Directed self-checking bench for mmm_ctrl with WIDTH=4.
// Revision: 1.0  initial release
// ============================================================================
`default_nettype none

module tb_mmm_ctrl;

  localparam int WIDTH = 4;
  localparam int IW    = 2;

  logic          clk;
  logic          rstb;
  logic          ena;
  logic          start;
  logic          abort;
  logic          ge_m;
  logic          busy;
  logic          done;
  logic          dp_ena;
  logic          dp_load;
  logic          dp_clear;
  logic          dp_sub;
  logic [IW-1:0] bit_idx;

  int checks;
  int errors;

  mmm_ctrl #(.WIDTH(WIDTH)) dut (
    .clk      (clk),
    .rstb     (rstb),
    .ena      (ena),
    .start    (start),
    .abort    (abort),
    .ge_m     (ge_m),
    .busy     (busy),
    .done     (done),
    .dp_ena   (dp_ena),
    .dp_load  (dp_load),
    .dp_clear (dp_clear),
    .dp_sub   (dp_sub),
    .bit_idx  (bit_idx)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Observed vector: {busy, done, dp_ena, dp_load, dp_clear, dp_sub, bit_idx}
  function automatic logic [7:0] snap();
    return {busy, done, dp_ena, dp_load, dp_clear, dp_sub, bit_idx};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    logic [7:0] got;
    rstb = 1'b0; ena = 1'b1; start = 1'b1; abort = 1'b0; ge_m = 1'b1;
    step();
    step();
    start = 1'b0; ge_m = 1'b0;
    #1;
    got = snap();
    checks++;
    if (got !== 8'b0000_1000) begin
      errors++;
      $display("FAIL reset got %b expected %b", got, 8'b0000_1000);
    end
    rstb = 1'b1;
    step();
    got = snap();
    checks++;
    if (got !== 8'b0000_1000) begin
      errors++;
      $display("FAIL reset_release got %b expected %b", got, 8'b0000_1000);
    end
  endtask

  task automatic test_nominal_run(input logic ge);
    logic [7:0] exp;
    logic [7:0] got;
    ge_m  = ge;
    start = 1'b1;
    step();
    start = 1'b0;
    for (int c = 1; c <= 8; c++) begin
      #1;
      case (c)
        1:          exp = 8'b1011_1000;
        2, 3, 4, 5: exp = {6'b1010_10, 2'(c - 2)};
        6:          exp = {5'b10101, ge, 2'b00};
        7:          exp = 8'b1100_1000;
        default:    exp = 8'b0000_1000;
      endcase
      got = snap();
      checks++;
      if (got !== exp) begin
        errors++;
        $display("FAIL nominal ge=%0b cycle %0d got %b expected %b", ge, c, got, exp);
      end
      if (c < 8) step();
    end
    ge_m = 1'b0;
  endtask

  task automatic test_abort();
    logic [7:0] exp;
    logic [7:0] got;
    start = 1'b1;
    step();
    start = 1'b0;
    for (int c = 1; c <= 8; c++) begin
      abort = (c == 4);
      #1;
      case (c)
        1:       exp = 8'b1011_1000;
        2, 3, 4: exp = {6'b1010_10, 2'(c - 2)};
        5:       exp = 8'b1010_0000;
        default: exp = 8'b0000_1000;
      endcase
      got = snap();
      checks++;
      if (got !== exp) begin
        errors++;
        $display("FAIL abort cycle %0d got %b expected %b", c, got, exp);
      end
      if (c < 8) step();
    end
    abort = 1'b0;
  endtask

  task automatic test_stall();
    logic [7:0] exp;
    logic [7:0] got;
    start = 1'b1;
    step();
    start = 1'b0;
    for (int c = 1; c <= 11; c++) begin
      ena = !(c >= 3 && c <= 5);
      #1;
      case (c)
        1:          exp = 8'b1011_1000;
        2:          exp = 8'b1010_1000;
        3, 4, 5:    exp = 8'b1000_1001;
        6:          exp = 8'b1010_1001;
        7:          exp = 8'b1010_1010;
        8:          exp = 8'b1010_1011;
        9:          exp = 8'b1010_1000;
        10:         exp = 8'b1100_1000;
        default:    exp = 8'b0000_1000;
      endcase
      got = snap();
      checks++;
      if (got !== exp) begin
        errors++;
        $display("FAIL stall cycle %0d got %b expected %b", c, got, exp);
      end
      if (c < 11) step();
    end
    ena = 1'b1;
  endtask

  task automatic test_reset_mid();
    logic [7:0] got;
    start = 1'b1;
    step();
    start = 1'b0;
    step();
    step();
    #1;
    got = snap();
    checks++;
    if (got !== 8'b1010_1001) begin
      errors++;
      $display("FAIL reset_mid_pre got %b expected %b", got, 8'b1010_1001);
    end
    rstb = 1'b0; start = 1'b1; abort = 1'b1;
    step();
    start = 1'b0; abort = 1'b0;
    #1;
    got = snap();
    checks++;
    if (got !== 8'b0000_1000) begin
      errors++;
      $display("FAIL reset_mid got %b expected %b", got, 8'b0000_1000);
    end
    rstb = 1'b1;
    step();
    step();
    got = snap();
    checks++;
    if (got !== 8'b0000_1000) begin
      errors++;
      $display("FAIL reset_mid_after got %b expected %b", got, 8'b0000_1000);
    end
  endtask

  task automatic test_ignored_start();
    logic [7:0] exp;
    logic [7:0] got;
    start = 1'b1;
    step();
    start = 1'b0;
    for (int c = 1; c <= 11; c++) begin
      start = (c == 3 || c == 7);
      #1;
      case (c)
        1:          exp = 8'b1011_1000;
        2, 3, 4, 5: exp = {6'b1010_10, 2'(c - 2)};
        6:          exp = 8'b1010_1000;
        7:          exp = 8'b1100_1000;
        default:    exp = 8'b0000_1000;
      endcase
      got = snap();
      checks++;
      if (got !== exp) begin
        errors++;
        $display("FAIL ignored_start cycle %0d got %b expected %b", c, got, exp);
      end
      if (c < 11) step();
    end
    start = 1'b1; abort = 1'b1;
    step();
    step();
    start = 1'b0; abort = 1'b0;
    got = snap();
    checks++;
    if (got !== 8'b0000_1000) begin
      errors++;
      $display("FAIL start_abort_idle got %b expected %b", got, 8'b0000_1000);
    end
    start = 1'b1; ena = 1'b0;
    step();
    start = 1'b0; ena = 1'b1;
    step();
    got = snap();
    checks++;
    if (got !== 8'b0000_1000) begin
      errors++;
      $display("FAIL start_ena_low got %b expected %b", got, 8'b0000_1000);
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_nominal_run(1'b1);
    test_nominal_run(1'b0);
    test_abort();
    test_stall();
    test_reset_mid();
    test_ignored_start();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
